// File: rtl/time_set_controller.sv
`default_nettype none
// ============================================================================
// Module   : time_set_controller
// Brief    : Debounced front-panel editor that loads time/alarm digits into
//            the clock core.
// Revision : 1.0 - initial release
// ============================================================================
module time_set_controller #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LOAD_CYCLES     = 120_000_000,
    parameter int TIMEOUT_CYCLES  = 1_000_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [1:0] cur_hour1,
    input  logic [3:0] cur_hour0,
    input  logic [3:0] cur_min1,
    input  logic [3:0] cur_min0,
    output logic [1:0] hour_in1,
    output logic [3:0] hour_in0,
    output logic [3:0] minute_in1,
    output logic [3:0] minute_in0,
    output logic       load_time,
    output logic       load_alarm,
    output logic [1:0] editing,
    output logic [1:0] edit_digit
);

    localparam int c_DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_LD_W  = (LOAD_CYCLES > 1)     ? $clog2(LOAD_CYCLES)     : 1;
    localparam int c_TMO_W = (TIMEOUT_CYCLES > 1)  ? $clog2(TIMEOUT_CYCLES)  : 1;

    localparam logic [c_DB_W-1:0]  c_DB_MAX  = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_LD_W-1:0]  c_LD_MAX  = c_LD_W'(LOAD_CYCLES - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_MAX = c_TMO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_EDIT_TIME  = 2'd1;
    localparam logic [1:0] c_EDIT_ALARM = 2'd2;
    localparam logic [1:0] c_COMMIT     = 2'd3;

    logic [3:0] w_raw;
    logic [3:0] w_press;

    assign w_raw = {btn_down, btn_up, btn_next, btn_mode};

    // Press pulses are registered, so a press acts 2 + DEBOUNCE_CYCLES + 1 edges after the raw edge
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_btn
            logic              r_sync1;
            logic              r_sync2;
            logic              r_level;
            logic              r_pulse;
            logic [c_DB_W-1:0] r_cnt;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_level <= 1'b0;
                    r_pulse <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_sync1 <= w_raw[gi];
                    r_sync2 <= r_sync1;
                    r_pulse <= 1'b0;
                    if (r_sync2 == r_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_DB_MAX) begin
                        r_cnt   <= '0;
                        r_level <= r_sync2;
                        r_pulse <= r_sync2;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_press[gi] = r_pulse;
        end
    endgenerate

    logic w_mode, w_next, w_up, w_down, w_any;

    assign w_mode = w_press[0];
    assign w_next = w_press[1] & ~w_press[0];
    assign w_up   = w_press[2] & ~|w_press[1:0];
    assign w_down = w_press[3] & ~|w_press[2:0];
    assign w_any  = |w_press;

    function automatic logic [3:0] f_step(input logic [3:0] v, input logic [3:0] vmax,
                                          input logic up);
        if (up) return (v >= vmax) ? 4'd0 : v + 4'd1;
        else    return (v == 4'd0 || v > vmax) ? vmax : v - 4'd1;
    endfunction

    logic [1:0]         r_state;
    logic [1:0]         r_digit;
    logic [1:0]         r_h1;
    logic [3:0]         r_h0, r_m1, r_m0;
    logic [1:0]         r_al_h1;
    logic [3:0]         r_al_h0, r_al_m1, r_al_m0;
    logic               r_load_time, r_load_alarm;
    logic [c_LD_W-1:0]  r_load_cnt;
    logic [c_TMO_W-1:0] r_tmo_cnt;

    logic [3:0] w_h0_max;
    logic [1:0] w_h1_new;
    logic [3:0] w_h0_new, w_m1_new, w_m0_new;

    assign w_h0_max = (r_h1 == 2'd2) ? 4'd3 : 4'd9;
    assign w_h1_new = 2'(f_step({2'b00, r_h1}, 4'd2, w_up));
    assign w_h0_new = f_step(r_h0, w_h0_max, w_up);
    assign w_m1_new = f_step(r_m1, 4'd5, w_up);
    assign w_m0_new = f_step(r_m0, 4'd9, w_up);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= c_IDLE;
            r_digit      <= 2'd0;
            r_h1         <= 2'd0;
            r_h0         <= 4'd0;
            r_m1         <= 4'd0;
            r_m0         <= 4'd0;
            r_al_h1      <= 2'd0;
            r_al_h0      <= 4'd0;
            r_al_m1      <= 4'd0;
            r_al_m0      <= 4'd0;
            r_load_time  <= 1'b0;
            r_load_alarm <= 1'b0;
            r_load_cnt   <= '0;
            r_tmo_cnt    <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_tmo_cnt <= '0;
                    if (w_mode) begin
                        r_state <= c_EDIT_TIME;
                        r_digit <= 2'd0;
                        r_h1    <= cur_hour1;
                        r_h0    <= cur_hour0;
                        r_m1    <= cur_min1;
                        r_m0    <= cur_min0;
                    end
                end
                c_EDIT_TIME, c_EDIT_ALARM: begin
                    r_tmo_cnt <= w_any ? '0 : r_tmo_cnt + 1'b1;
                    if (w_mode) begin
                        r_digit <= 2'd0;
                        if (r_state == c_EDIT_TIME) begin
                            r_state <= c_EDIT_ALARM;
                            r_h1    <= r_al_h1;
                            r_h0    <= r_al_h0;
                            r_m1    <= r_al_m1;
                            r_m0    <= r_al_m0;
                        end else begin
                            r_state <= c_IDLE;
                        end
                    end else if (w_next) begin
                        if (r_digit == 2'd3) begin
                            r_state    <= c_COMMIT;
                            r_load_cnt <= '0;
                            if (r_state == c_EDIT_TIME) begin
                                r_load_time <= 1'b1;
                            end else begin
                                r_load_alarm <= 1'b1;
                                r_al_h1      <= r_h1;
                                r_al_h0      <= r_h0;
                                r_al_m1      <= r_m1;
                                r_al_m0      <= r_m0;
                            end
                        end else begin
                            r_digit <= r_digit + 2'd1;
                        end
                    end else if (w_up || w_down) begin
                        case (r_digit)
                            2'd0: begin
                                r_h1 <= w_h1_new;
                                // Keep the hour legal when the tens digit lands on 2
                                if (w_h1_new == 2'd2 && r_h0 > 4'd3) r_h0 <= 4'd3;
                            end
                            2'd1:    r_h0 <= w_h0_new;
                            2'd2:    r_m1 <= w_m1_new;
                            default: r_m0 <= w_m0_new;
                        endcase
                    end else if (r_tmo_cnt == c_TMO_MAX) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    if (r_load_cnt == c_LD_MAX) begin
                        r_state      <= c_IDLE;
                        r_load_time  <= 1'b0;
                        r_load_alarm <= 1'b0;
                        r_load_cnt   <= '0;
                    end else begin
                        r_load_cnt <= r_load_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign hour_in1   = r_h1;
    assign hour_in0   = r_h0;
    assign minute_in1 = r_m1;
    assign minute_in0 = r_m0;
    assign load_time  = r_load_time;
    assign load_alarm = r_load_alarm;
    assign editing    = r_state;
    assign edit_digit = r_digit;

endmodule
`default_nettype wire
